// File: rtl/imem_ctrl_pkg.sv
// Shared types, constants and address classification for the instruction
// memory load/fetch controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  // A fetch is serviceable when word aligned and its word index lies inside the RAM.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_fetch_pipe.sv
// One-stage fetch response register: turns an issued (or rejected) request
// into a single-cycle response pulse, selecting RAM data or the NOP word.
module imem_fetch_pipe
  import imem_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic        fault,
  input  logic [31:0] mem_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_fault,
  output logic [31:0] cpu_rdata
);

  // Response stage: a request seen this cycle is answered on the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      cpu_fault  <= 1'b0;
    end else begin
      cpu_rvalid <= issue | fault;
      cpu_fault  <= fault;
    end
  end

  // RAM read data only arrives in the response cycle, so the data mux stays combinational.
  always_comb begin
    cpu_rdata = 32'h0;
    if (cpu_rvalid) begin
      cpu_rdata = cpu_fault ? NOP_WORD : mem_rdata;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction memory sequencing controller: fills the RAM from the loader
// stream after reset or on reload, then serves CPU fetches one per cycle.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  input  logic                     reload_req,
  input  logic                     cpu_req,
  input  logic [31:0]              cpu_addr,
  output logic                     cpu_stall,
  output logic                     cpu_rvalid,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_fault,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  output logic                     load_done
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic          ld_fire;
  logic          ld_end;
  logic          req_run;
  logic          good;
  logic          issue;
  logic          bad;

  // Classify this cycle's loader and fetch activity.
  always_comb begin
    ld_fire = ld_valid && ld_ready && (state == LOAD);
    ld_end  = ld_fire && (ld_last || (cnt == LAST_IDX));
    req_run = cpu_req && (state == RUN);
    good    = addr_ok(cpu_addr, 32'(DEPTH));
    issue   = req_run && good;
    bad     = req_run && !good;
  end

  // Next-state and write-index selection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOAD: begin
        if (ld_end) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (ld_fire) begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      RUN: begin
        // A request in the reload cycle still needs its response delivered.
        if (reload_req) begin
          state_nxt = (issue || bad) ? DRAIN : LOAD;
        end
      end
      DRAIN: begin
        state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Zero-latency RAM port drive: loader writes in LOAD, fetch reads in RUN.
  always_comb begin
    mem_en    = ld_fire | issue;
    mem_we    = ld_fire;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (ld_fire) begin
      mem_addr  = cnt;
      mem_wdata = ld_data;
    end else if (issue) begin
      mem_addr = cpu_addr[2 +: AW];
    end
  end

  // Controller state plus registered decodes of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      ld_ready  <= 1'b0;
      cpu_stall <= 1'b1;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ld_ready  <= (state_nxt == LOAD);
      cpu_stall <= (state_nxt != RUN);
      load_done <= (state_nxt == RUN);
    end
  end

  imem_fetch_pipe #(
    .NOP_WORD (NOP_WORD)
  ) u_fetch_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .fault      (bad),
    .mem_rdata  (mem_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_fault  (cpu_fault),
    .cpu_rdata  (cpu_rdata)
  );

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: stimulus pushes expected RAM writes
// and fetch responses; an independent monitor pops and compares them.
module tb_imem_load_ctrl;

  localparam int          DEPTH = 32;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = 32'h0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          reload_req = 1'b0;
  logic          cpu_req = 1'b0;
  logic [31:0]   cpu_addr = 32'h0;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          cpu_fault;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          load_done;

  imem_load_ctrl #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload_req(reload_req),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_done(load_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM that the controller owns.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct { logic [31:0] data; logic fault; int due; } rsp_t;
  typedef struct { int idx; logic [31:0] data; } wr_t;

  rsp_t        rq[$];
  wr_t         wq[$];
  logic [31:0] img [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every RAM write and every fetch response against the queues.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      while (rq.size() > 0 && rq[0].due < cyc) begin
        check("rsp_missing", 32'(rq[0].due), 32'(cyc));
        void'(rq.pop_front());
      end
      if (cpu_rvalid) begin
        if (rq.size() == 0) begin
          check("rsp_unexpected", {31'h0, cpu_rvalid}, 32'h0);
        end else begin
          rsp_t e;
          e = rq.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.due));
          check("rsp_data", cpu_rdata, e.data);
          check("rsp_fault", {31'h0, cpu_fault}, {31'h0, e.fault});
        end
      end
      if (mem_en && mem_we) begin
        if (wq.size() == 0) begin
          check("wr_unexpected", {31'h0, mem_we}, 32'h0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(w.idx));
          check("wr_data", mem_wdata, w.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n words; the image model stores word i at index i.
  task automatic load(input int n, input bit use_last, input bit expect_run);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      ld_last  = use_last && (i == n - 1);
      #1;
      check("ld_ready_load", {31'h0, ld_ready}, 32'h1);
      check("done_during_load", {31'h0, load_done}, 32'h0);
      img[i] = ld_data;
      wq.push_back('{idx: i, data: ld_data});
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (expect_run) begin
      check("load_done_after", {31'h0, load_done}, 32'h1);
      check("stall_after", {31'h0, cpu_stall}, 32'h0);
      check("ld_ready_after", {31'h0, ld_ready}, 32'h0);
    end
  endtask

  // One-cycle fetch with model-computed response; leaves cpu_req asserted.
  task automatic fetch(input logic [31:0] a);
    logic bad;
    int   widx;
    widx = int'(a / 4);
    bad  = (a % 4 != 0) || (a / 4 >= DEPTH);
    cpu_req  = 1'b1;
    cpu_addr = a;
    #1;
    check("issue_en", {31'h0, mem_en}, {31'h0, !bad});
    if (!bad) begin
      check("issue_we", {31'h0, mem_we}, 32'h0);
      check("issue_addr", 32'(mem_addr), 32'(widx));
    end
    rq.push_back('{data: bad ? NOP : img[widx], fault: bad, due: cyc + 1});
    step();
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check("rst_stall", {31'h0, cpu_stall}, 32'h1);
    check("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_done", {31'h0, load_done}, 32'h0);
    rst = 1'b0;
    #1;
    check("ld_ready_before_edge", {31'h0, ld_ready}, 32'h0);
    step();

    // Four-word image with ld_last on the final word.
    load(4, 1'b1, 1'b1);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); idle();
    fetch(32'h2); fetch(32'h80); idle();

    // Reload with a concurrent fetch: response drains, then LOAD.
    reload_req = 1'b1;
    fetch(32'h4);
    reload_req = 1'b0;
    cpu_req    = 1'b0;
    check("drain_stall", {31'h0, cpu_stall}, 32'h1);
    check("drain_done", {31'h0, load_done}, 32'h0);
    check("drain_ld_ready", {31'h0, ld_ready}, 32'h0);
    step();
    check("reload_ld_ready", {31'h0, ld_ready}, 32'h1);
    check("reload_stall", {31'h0, cpu_stall}, 32'h1);

    // Full-depth image without ld_last, then an ignored extra word.
    load(DEPTH, 1'b0, 1'b1);
    ld_valid = 1'b1;
    ld_data  = $urandom;
    #1;
    check("extra_ld_ready", {31'h0, ld_ready}, 32'h0);
    check("extra_mem_en", {31'h0, mem_en}, 32'h0);
    step();
    ld_valid = 1'b0;

    // Randomised fetch traffic over good, misaligned and out-of-range addresses.
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        0:       idle();
        1:       fetch(32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3)));
        2:       fetch(32'(DEPTH * 4) + 32'($urandom_range(0, 1000)));
        3:       fetch($urandom | 32'h8000_0000);
        default: fetch(32'($urandom_range(0, DEPTH - 1)) * 4);
      endcase
    end
    idle();

    // Reload with no request in flight goes straight to LOAD.
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    check("direct_ld_ready", {31'h0, ld_ready}, 32'h1);
    check("direct_done", {31'h0, load_done}, 32'h0);
    load(2, 1'b1, 1'b1);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); idle();

    // Reset in the middle of a load.
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    load(2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    rq.delete();
    wq.delete();
    check("mid_rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check("mid_rst_stall", {31'h0, cpu_stall}, 32'h1);
    check("mid_rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("mid_rst_done", {31'h0, load_done}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ld_ready0", {31'h0, ld_ready}, 32'h0);
    step();
    load(3, 1'b1, 1'b1);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); idle();
    idle();
    idle();

    check("rsp_queue_empty", 32'(rq.size()), 32'h0);
    check("wr_queue_empty", 32'(wq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: cycle %0d reached without completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencing controller in front of the instruction memory. It owns the single port of a synchronous-read, word-organised instruction RAM. After reset it fills the RAM from a streaming loader interface while holding the CPU stalled, then serves CPU instruction fetches. It sits between the fetch stage, the boot/debug loader and the instruction RAM, and replaces the CPU's direct, asynchronous view of instruction storage.

## Interface
- DEPTH, 32, number of 32-bit instruction words; power of two, ≥ 2
- NOP_WORD, 32'h0000_0013, word returned for faulting fetches
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader instruction word
- ld_last  in  1  marks final word of image, qualified by ld_valid
- ld_ready  out  1  controller accepts loader word this cycle
- reload_req  in  1  single-cycle pulse; request re-load of image
- cpu_req  in  1  fetch request
- cpu_addr  in  32  fetch byte address
- cpu_stall  out  1  CPU must hold cpu_req/cpu_addr
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  32  fetched word
- cpu_fault  out  1  fetch was misaligned or out of range, qualified by cpu_rvalid
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  $clog2(DEPTH)  RAM word index
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en && !mem_we
- load_done  out  1  image loaded and CPU service active

## Operation
- States: LOAD, RUN, DRAIN. Reset enters LOAD.
- LOAD:
  - ld_ready=1 and cpu_stall=1.
  - On ld_valid: mem_en=mem_we=1, mem_addr=word counter, mem_wdata=ld_data, and the counter increments.
  - Go to RUN when an accepted word has ld_last=1, or when the accepted word is at index DEPTH-1. In either case, clear the counter.
  - Words above the last loaded index are not cleared.
- RUN:
  - ld_ready=0, cpu_stall=0, load_done=1.
  - A cpu_req is classified as:
    - aligned: cpu_addr[1:0]==0
    - in range: cpu_addr[31:2] < DEPTH
  - A good request issues mem_en=1, mem_we=0, mem_addr=cpu_addr[2+:$clog2(DEPTH)]. The next cycle gives cpu_rvalid=1, cpu_rdata=mem_rdata, cpu_fault=0.
  - A bad request issues no RAM access. The next cycle gives cpu_rvalid=1, cpu_rdata=NOP_WORD, cpu_fault=1.
  - Back-to-back requests are fully pipelined: one per cycle.
- reload_req in RUN:
  - If a read is in flight this cycle, go to DRAIN. Otherwise go to LOAD.
  - cpu_stall=1 from the next cycle.
  - A cpu_req in the same cycle as reload_req is still served.
- DRAIN:
  - Only completes the outstanding response (cpu_rvalid), then goes to LOAD.
  - cpu_stall=1 and load_done=0.
- reload_req outside RUN is ignored.
- ld_valid outside LOAD is ignored; ld_ready=0.

## Timing
- Reset values:
  - state=LOAD, counter=0
  - ld_ready=0, cpu_stall=1, cpu_rvalid=0, cpu_rdata=0, cpu_fault=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - load_done=0
- ld_ready, cpu_stall and load_done are registered state decodes.
  - ld_ready rises in the first clk edge after rst falls.
- mem_* outputs are combinational from state, counter and request inputs: zero-latency issue.
- Fetch latency: exactly 1 cycle, request to cpu_rvalid. cpu_rvalid is a single-cycle pulse per request.
- Loader transfer occurs on ld_valid && ld_ready. Throughput is one word per cycle.
- LOAD→RUN: load_done=1 and cpu_stall=0 in the cycle after the final accepted word. That write completes in the same cycle it is accepted.
- rst asserted mid-load or mid-fetch: everything aborts immediately. Any pending cpu_rvalid is dropped. RAM contents are not guaranteed.

## Structure
- Package imem_ctrl_pkg:
  - state enum {LOAD, RUN, DRAIN}
  - NOP_WORD default constant
  - helper function addr_ok(addr, depth)
- One natural sub-module, imem_fetch_pipe: the one-stage response register.
  - Inputs: issue, fault.
  - Outputs: cpu_rvalid, cpu_fault, and the mux of mem_rdata vs NOP_WORD.
  - Keeps the FSM separate from the response path.
- RAM itself stays outside this block.

## Test plan
- Reset then stream 4 words (0x00500093, 0x00A00113, 0x002081B3, 0x00000063), the last with ld_last → 4 RAM writes at indices 0–3; load_done=1 and cpu_stall=0 one cycle after the last word.
- Stream DEPTH words with no ld_last → transitions to RUN after index 31; a 33rd ld_valid sees ld_ready=0.
- Fetches at 0x0, 0x4, 0x8 on consecutive cycles → cpu_rvalid on three consecutive cycles with the loaded words, cpu_fault=0.
- Fetch at 0x2 and at 0x80 → cpu_rvalid with cpu_rdata=0x00000013, cpu_fault=1, mem_en=0 in the request cycle.
- reload_req concurrent with fetch at 0x4 → response delivered (DRAIN), then LOAD with cpu_stall=1 and ld_ready=1; reload 2 words → RUN; fetch 0x0 returns the new word.
- Assert rst during LOAD after 2 words → all outputs at reset values; reload from index 0 succeeds.
